// File: rtl/cdc_hs_rx.sv
// Destination-side receiver of the toggle-handshake CDC path: captures the quasi-static
// source word on a new request toggle, offers it on valid/ready, and returns an ack toggle.
module cdc_hs_rx #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_sync,
  input  logic [DATA_WIDTH-1:0] data_async,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ack_tog,
  output logic                  overrun,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  logic [0:0] state;
  logic       req_q;
  logic       new_req;

  assign new_req   = (req_sync != req_q);
  assign out_valid = (state == ST_VALID);

  // req_q only follows req_sync on capture, so a request arriving while a word is
  // held stays pending and is picked up from IDLE after that word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_q      <= 1'b0;
      out_data   <= '0;
      ack_tog    <= 1'b0;
      overrun    <= 1'b0;
      xfer_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (new_req) begin
            out_data <= data_async;
            req_q    <= req_sync;
            state    <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (new_req) begin
            overrun <= 1'b1;
          end
          if (out_ready) begin
            ack_tog    <= ~ack_tog;
            xfer_count <= xfer_count + CNT_WIDTH'(1);
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Self-checking bench for cdc_hs_rx: directed handshake scenarios plus a randomized
// source/sink, compared against a transaction-count reference model.
module tb_cdc_hs_rx;

  localparam int DW = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          req_sync;
  logic [DW-1:0] data_async;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          ack_tog;
  logic          overrun;
  logic [CW-1:0] xfer_count;

  int checks;
  int failures;

  // Reference model: words captured/accepted so far, last captured word, sticky overrun.
  int            m_captured;
  int            m_accepted;
  logic [DW-1:0] m_word;
  logic          m_overrun;

  cdc_hs_rx #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_sync   (req_sync),
    .data_async (data_async),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .ack_tog    (ack_tog),
    .overrun    (overrun),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_captured = 0;
    m_accepted = 0;
    m_word     = '0;
    m_overrun  = 1'b0;
  endtask

  // A word is held while more words were captured than accepted; the parity of the
  // capture count is the request level already serviced.
  task automatic modelEdge(input logic r, input logic [DW-1:0] d, input logic rdy);
    logic held;
    logic pending;
    held    = (m_captured != m_accepted);
    pending = (r != m_captured[0]);
    if (held) begin
      if (pending) m_overrun = 1'b1;
      if (rdy) m_accepted++;
    end else if (pending) begin
      m_captured++;
      m_word = d;
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".out_valid"},  32'(out_valid),  32'(m_captured != m_accepted));
    checkOutput({tag, ".out_data"},   32'(out_data),   32'(m_word));
    checkOutput({tag, ".ack_tog"},    32'(ack_tog),    32'(m_accepted % 2));
    checkOutput({tag, ".overrun"},    32'(overrun),    32'(m_overrun));
    checkOutput({tag, ".xfer_count"}, 32'(xfer_count), 32'(m_accepted % (1 << CW)));
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic [DW-1:0] d, input logic rdy);
    req_sync   = r;
    data_async = d;
    out_ready  = rdy;
    @(posedge clk);
    modelEdge(r, d, rdy);
    #1;
    compareAll(tag);
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    req_sync   = 1'($urandom);
    data_async = DW'($urandom);
    out_ready  = 1'($urandom);
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    compareAll("in_reset");
    req_sync = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    compareAll("after_reset");
  endtask

  initial begin
    logic          src_req;
    logic          ack_d1;
    logic          ack_d2;
    logic [DW-1:0] src_data;

    checks   = 0;
    failures = 0;
    rst_n      = 1'b0;
    req_sync   = 1'b0;
    data_async = '0;
    out_ready  = 1'b0;
    #2;

    doReset();
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.out_data", 32'(out_data), 32'd0);

    // Single transfer
    applyStimulus("single_cap", 1'b1, 4'hA, 1'b1);
    checkOutput("single.valid", 32'(out_valid), 32'd1);
    checkOutput("single.data", 32'(out_data), 32'hA);
    applyStimulus("single_acc", 1'b1, 4'hA, 1'b1);
    checkOutput("single.ack", 32'(ack_tog), 32'd1);
    checkOutput("single.count", 32'(xfer_count), 32'd1);
    checkOutput("single.valid_low", 32'(out_valid), 32'd0);

    // Backpressure with the source bus wandering after capture
    applyStimulus("bp_cap", 1'b0, 4'hA, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("bp_hold", 1'b0, 4'h3, 1'b0);
    end
    checkOutput("bp.data_held", 32'(out_data), 32'hA);
    checkOutput("bp.ack_held", 32'(ack_tog), 32'd1);
    applyStimulus("bp_acc", 1'b0, 4'h3, 1'b1);
    checkOutput("bp.ack", 32'(ack_tog), 32'd0);
    checkOutput("bp.count", 32'(xfer_count), 32'd2);

    // Overrun: second toggle while a word is held
    applyStimulus("ov_cap", 1'b1, 4'hA, 1'b0);
    applyStimulus("ov_violate", 1'b0, 4'h5, 1'b0);
    checkOutput("ov.flag", 32'(overrun), 32'd1);
    checkOutput("ov.data_held", 32'(out_data), 32'hA);
    applyStimulus("ov_acc", 1'b0, 4'h5, 1'b1);
    checkOutput("ov.idle_gap", 32'(out_valid), 32'd0);
    applyStimulus("ov_recap", 1'b0, 4'h5, 1'b0);
    checkOutput("ov.pending_valid", 32'(out_valid), 32'd1);
    checkOutput("ov.pending_data", 32'(out_data), 32'h5);
    applyStimulus("ov_acc2", 1'b0, 4'h5, 1'b1);
    applyStimulus("ov_idle", 1'b0, 4'h5, 1'b1);
    checkOutput("ov.sticky", 32'(overrun), 32'd1);
    checkOutput("ov.count", 32'(xfer_count), 32'd4);

    // Streaming 17 words through a 4-bit counter
    doReset();
    src_req = 1'b0;
    for (int i = 0; i < 17; i++) begin
      src_req  = ~src_req;
      src_data = DW'($urandom);
      applyStimulus("stream_cap", src_req, src_data, 1'b1);
      checkOutput("stream.word", 32'(out_data), 32'(src_data));
      applyStimulus("stream_acc", src_req, src_data, 1'b1);
      checkOutput("stream.ack", 32'(ack_tog), 32'((i + 1) % 2));
      applyStimulus("stream_idle", src_req, src_data, 1'b1);
    end
    checkOutput("stream.count_wrap", 32'(xfer_count), 32'd1);
    checkOutput("stream.no_overrun", 32'(overrun), 32'd0);

    // Reset while a word is held
    applyStimulus("rv_cap", ~src_req, 4'h9, 1'b0);
    applyStimulus("rv_hold", ~src_req, 4'h9, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rv.valid", 32'(out_valid), 32'd0);
    checkOutput("rv.ack", 32'(ack_tog), 32'd0);
    checkOutput("rv.data", 32'(out_data), 32'd0);
    doReset();

    // Randomized source that waits for its synchronized ack, and a random sink
    src_req  = 1'b0;
    src_data = '0;
    ack_d1   = 1'b0;
    ack_d2   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (src_req == ack_d2 && ($urandom % 3) == 0) begin
        src_data = DW'($urandom);
        src_req  = ~src_req;
      end
      applyStimulus("random", src_req, src_data, 1'($urandom));
      ack_d2 = ack_d1;
      ack_d1 = 1'(m_accepted % 2);
    end
    checkOutput("random.no_overrun", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
